// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad path (scanner and decoder).
package keypad_pkg;

  localparam int DEF_COLS = 4;
  localparam int DEF_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_res_t;

  // Width of {row_idx, col_idx}
  function automatic int code_w(input int cols, input int rows);
    return $clog2(cols) + $clog2(rows);
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad decoder bus: scanner column drive and row pins in, decoded key events out.
interface keypad_if
  import keypad_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) ();

  localparam int KW = code_w(COLS, ROWS);

  logic [COLS-1:0] col;
  logic [ROWS-1:0] row_raw;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;
  logic            key_release;
  logic            multi_key;

  modport master (
    output col,
    output row_raw,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  key_release,
    input  multi_key
  );

  modport slave (
    input  col,
    input  row_raw,
    output key_code,
    output key_valid,
    output key_held,
    output key_release,
    output multi_key
  );

endinterface

// File: rtl/row_sync.sv
// Two-flop synchroniser for asynchronous row pins, preset to a chosen idle level.
module row_sync #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_p0;
  logic [W-1:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_decoder.sv
// Frame-based keypad decoder: builds one keypad frame per scan rotation and debounces across frames.
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int COLS            = DEF_COLS,
  parameter int ROWS            = DEF_ROWS,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter bit ROW_ACTIVE_LOW  = 1'b1,
  parameter bit COL_ACTIVE_LOW  = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.slave  bus
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int KW    = code_w(COLS, ROWS);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [ROWS-1:0]  ROW_IDLE = {ROWS{ROW_ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] DF_CNT   = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               ONE_SHOT = (DEBOUNCE_FRAMES == 1);

  function automatic logic [1:0] sat_pop(input logic [ROWS-1:0] v);
    int n;
    n = $countones(v);
    return (n >= 2) ? 2'd2 : 2'(n);
  endfunction

  function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd2) ? 2'd2 : s[1:0];
  endfunction

  // Lowest active row wins, so scan downwards and let the last match stick.
  function automatic logic [RW-1:0] row_index(input logic [ROWS-1:0] v);
    logic [RW-1:0] idx;
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (v[i]) idx = i[RW-1:0];
    end
    return idx;
  endfunction

  function automatic logic [CW-1:0] col_index(input logic [COLS-1:0] v);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (v[i]) idx = i[CW-1:0];
    end
    return idx;
  endfunction

  logic [ROWS-1:0] row_sync_q;
  logic [ROWS-1:0] row_s;
  logic [ROWS-1:0] row_q;
  logic [COLS-1:0] col_n;
  logic [COLS-1:0] col_d;

  logic            step;
  logic            col_onehot;
  logic            leave_first;
  logic            leave_last;
  logic            active;
  logic            frame_end;

  logic            in_frame_q;
  logic [1:0]      hits_q;
  logic [KW-1:0]   first_q;
  logic [1:0]      hit_here;
  logic [1:0]      base_hits;
  logic [KW-1:0]   base_first;
  logic [1:0]      hits_sum;
  logic [KW-1:0]   first_sum;
  frame_res_t      res;

  state_t          state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [KW-1:0]   cand_q, cand_n;
  logic [KW-1:0]   key_code_q, code_n;
  logic            key_valid_q, valid_n;
  logic            key_release_q, release_n;
  logic            key_held_q, held_n;
  logic            multi_q, multi_n;

  row_sync #(
    .W       (ROWS),
    .RST_VAL (ROW_IDLE)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.row_raw),
    .q     (row_sync_q)
  );

  assign row_s = ROW_ACTIVE_LOW ? ~row_sync_q : row_sync_q;
  assign col_n = COL_ACTIVE_LOW ? ~bus.col : bus.col;

  // Step: the scanner has moved on; row_q still belongs to column col_d.
  assign step        = (col_n != col_d);
  assign col_onehot  = $onehot(col_d);
  assign leave_first = step && col_onehot && col_d[0];
  assign leave_last  = step && col_onehot && col_d[COLS-1];
  assign active      = leave_first || in_frame_q;
  assign frame_end   = leave_last && active;

  assign hit_here   = sat_pop(row_q);
  assign base_hits  = leave_first ? 2'd0 : hits_q;
  assign base_first = leave_first ? '0 : first_q;
  assign hits_sum   = sat_add(base_hits, hit_here);
  assign first_sum  = (base_hits == 2'd0 && row_q != '0) ?
                      {row_index(row_q), col_index(col_d)} : base_first;

  always_comb begin
    res = NONE;
    if (hits_sum >= 2'd2)      res = MULTI;
    else if (hits_sum == 2'd1) res = SINGLE;
  end

  // Stage p0: column tracking and frame accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_d      <= '0;
      row_q      <= '0;
      in_frame_q <= 1'b0;
      hits_q     <= 2'd0;
      first_q    <= '0;
    end else begin
      col_d <= col_n;
      row_q <= row_s;
      if (step) begin
        // An invalid column, the frame end, or an unsynchronised frame all clear the accumulators.
        if (!col_onehot || leave_last || !active) begin
          in_frame_q <= 1'b0;
          hits_q     <= 2'd0;
          first_q    <= '0;
        end else begin
          in_frame_q <= 1'b1;
          hits_q     <= hits_sum;
          first_q    <= first_sum;
        end
      end
    end
  end

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    cand_n    = cand_q;
    code_n    = key_code_q;
    valid_n   = 1'b0;
    release_n = 1'b0;
    multi_n   = multi_q;
    if (frame_end) begin
      multi_n = (res == MULTI);
      case (state_q)
        IDLE: begin
          if (res == SINGLE) begin
            cand_n = first_sum;
            if (ONE_SHOT) begin
              state_n = PRESSED;
              code_n  = first_sum;
              valid_n = 1'b1;
              cnt_n   = '0;
            end else begin
              state_n = DEBOUNCE;
              cnt_n   = CNT_ONE;
            end
          end
        end
        DEBOUNCE: begin
          if (res == SINGLE && first_sum == cand_q) begin
            if (cnt_inc == DF_CNT) begin
              state_n = PRESSED;
              code_n  = cand_q;
              valid_n = 1'b1;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PRESSED: begin
          if (res == NONE) begin
            if (ONE_SHOT) begin
              state_n   = IDLE;
              release_n = 1'b1;
              cnt_n     = '0;
            end else begin
              state_n = RELEASE;
              cnt_n   = CNT_ONE;
            end
          end
        end
        RELEASE: begin
          if (res == NONE) begin
            if (cnt_inc == DF_CNT) begin
              state_n   = IDLE;
              release_n = 1'b1;
              cnt_n     = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = PRESSED;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
    held_n = (state_n == PRESSED) || (state_n == RELEASE);
  end

  // Stage p1: debounce state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cand_q        <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_held_q    <= 1'b0;
      multi_q       <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      cand_q        <= cand_n;
      key_code_q    <= code_n;
      key_valid_q   <= valid_n;
      key_release_q <= release_n;
      key_held_q    <= held_n;
      multi_q       <= multi_n;
    end
  end

  assign bus.key_code    = key_code_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_release = key_release_q;
  assign bus.key_held    = key_held_q;
  assign bus.multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder: behavioural column scanner and key matrix, scoreboard of key events.
module tb_keypad_decoder;
  import keypad_pkg::*;

  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int DWELL = 4;
  localparam int FRAME = COLS * DWELL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  keypad_decoder #(
    .COLS            (COLS),
    .ROWS            (ROWS),
    .DEBOUNCE_FRAMES (4),
    .ROW_ACTIVE_LOW  (1'b1),
    .COL_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Key matrix: a pressed key pulls its row low while its column is driven.
  logic [COLS-1:0] pressed [ROWS];
  always_comb begin
    bus.row_raw = '1;
    for (int r = 0; r < ROWS; r++) begin
      if ((pressed[r] & bus.col) != '0) bus.row_raw[r] = 1'b0;
    end
  end

  // Column scanner, 4-cycle dwell; the column-1 slot can be overridden.
  int              scan_idx   = 0;
  int              scan_dwell = 0;
  logic            force_en   = 1'b0;
  logic [COLS-1:0] force_val  = '0;
  initial begin
    bus.col = 4'b0001;
    forever begin
      @(posedge clk);
      #1;
      if (scan_dwell == DWELL - 1) begin
        scan_dwell = 0;
        scan_idx   = (scan_idx + 1) % COLS;
      end else begin
        scan_dwell++;
      end
      bus.col = (force_en && scan_idx == 1) ? force_val : (COLS'(1) << scan_idx);
    end
  end

  typedef struct packed {
    logic       rel;
    logic [3:0] code;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_ev;
  int   total = 0;
  int   bad   = 0;
  logic valid_prev = 1'b0;
  logic rel_prev   = 1'b0;

  always @(negedge clk) begin
    if (bus.key_valid) begin
      total++;
      if (valid_prev) begin
        bad++;
        $display("FAIL valid_width got=2+ cycles want=1 cycle t=%0t", $time);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got code=%b want=no pulse t=%0t", bus.key_code, $time);
      end else begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.rel !== 1'b0 || mon_ev.code !== bus.key_code) begin
          bad++;
          $display("FAIL valid_event got=valid code=%b want rel=%0b code=%b", bus.key_code, mon_ev.rel, mon_ev.code);
        end
      end
    end
    if (bus.key_release) begin
      total++;
      if (rel_prev) begin
        bad++;
        $display("FAIL release_width got=2+ cycles want=1 cycle t=%0t", $time);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_release got code=%b want=no pulse t=%0t", bus.key_code, $time);
      end else begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.rel !== 1'b1 || mon_ev.code !== bus.key_code) begin
          bad++;
          $display("FAIL release_event got=release code=%b want rel=%0b code=%b", bus.key_code, mon_ev.rel, mon_ev.code);
        end
      end
    end
    valid_prev <= bus.key_valid;
    rel_prev   <= bus.key_release;
  end

  task automatic wait_frames(input int n);
    repeat (FRAME * n) @(posedge clk);
    #2;
  endtask

  task automatic settle;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic sync_frame;
    int n;
    n = 0;
    while (!(scan_idx == 0 && scan_dwell == 0) && n < 4 * FRAME) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!(scan_idx == 0 && scan_dwell == 0)) begin
      total++;
      bad++;
      $display("FAIL sync_timeout got idx=%0d dwell=%0d want=0/0", scan_idx, scan_dwell);
    end
  endtask

  task automatic release_all;
    for (int r = 0; r < ROWS; r++) pressed[r] = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++; if (bus.key_code !== 4'b0000) begin bad++; $display("FAIL rst_code got=%b want=0000", bus.key_code); end
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.key_valid); end
    total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL rst_held got=%b want=0", bus.key_held); end
    total++; if (bus.key_release !== 1'b0) begin bad++; $display("FAIL rst_release got=%b want=0", bus.key_release); end
    total++; if (bus.multi_key !== 1'b0) begin bad++; $display("FAIL rst_multi got=%b want=0", bus.multi_key); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dut.state_q, IDLE); end
    total++; if (dut.row_sync_q !== 4'hF) begin bad++; $display("FAIL rst_sync got=%h want=f", dut.row_sync_q); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_frames(2);
    settle;
    total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL idle_held got=%b want=0", bus.key_held); end
  endtask

  task automatic test_press;
    exp_q.push_back({1'b0, 4'b1001});
    sync_frame;
    pressed[2][1] = 1'b1;
    wait_frames(3);
    settle;
    total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL press_early got held=%b want=0", bus.key_held); end
    total++; if (dut.state_q !== DEBOUNCE) begin bad++; $display("FAIL press_deb got=%0d want=%0d", dut.state_q, DEBOUNCE); end
    sync_frame;
    wait_frames(1);
    settle;
    total++; if (bus.key_held !== 1'b1) begin bad++; $display("FAIL press_held got=%b want=1", bus.key_held); end
    total++; if (bus.key_code !== 4'b1001) begin bad++; $display("FAIL press_code got=%b want=1001", bus.key_code); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL press_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_release;
    exp_q.push_back({1'b1, 4'b1001});
    sync_frame;
    pressed[2][1] = 1'b0;
    wait_frames(3);
    settle;
    total++; if (bus.key_held !== 1'b1) begin bad++; $display("FAIL rel_early got held=%b want=1", bus.key_held); end
    total++; if (exp_q.size() != 1) begin bad++; $display("FAIL rel_early_pulse got pending=%0d want=1", exp_q.size()); end
    sync_frame;
    settle;
    total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL rel_held got=%b want=0", bus.key_held); end
    total++; if (bus.key_code !== 4'b1001) begin bad++; $display("FAIL rel_code got=%b want=1001", bus.key_code); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rel_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_short;
    sync_frame;
    pressed[2][1] = 1'b1;
    wait_frames(3);
    pressed[2][1] = 1'b0;
    wait_frames(2);
    settle;
    total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL short_held got=%b want=0", bus.key_held); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL short_state got=%0d want=%0d", dut.state_q, IDLE); end
  endtask

  task automatic test_multi;
    sync_frame;
    pressed[0][0] = 1'b1;
    pressed[3][2] = 1'b1;
    wait_frames(1);
    settle;
    total++; if (bus.multi_key !== 1'b1) begin bad++; $display("FAIL multi_flag got=%b want=1", bus.multi_key); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL multi_state got=%0d want=%0d", dut.state_q, IDLE); end
    exp_q.push_back({1'b0, 4'b0000});
    sync_frame;
    pressed[3][2] = 1'b0;
    wait_frames(4);
    settle;
    total++; if (bus.multi_key !== 1'b0) begin bad++; $display("FAIL multi_clear got=%b want=0", bus.multi_key); end
    total++; if (bus.key_held !== 1'b1) begin bad++; $display("FAIL multi_held got=%b want=1", bus.key_held); end
    total++; if (bus.key_code !== 4'b0000) begin bad++; $display("FAIL multi_code got=%b want=0000", bus.key_code); end
    sync_frame;
    pressed[1][3] = 1'b1;
    wait_frames(2);
    settle;
    total++; if (bus.multi_key !== 1'b1) begin bad++; $display("FAIL block_multi got=%b want=1", bus.multi_key); end
    total++; if (dut.state_q !== PRESSED) begin bad++; $display("FAIL block_state got=%0d want=%0d", dut.state_q, PRESSED); end
    exp_q.push_back({1'b1, 4'b0000});
    sync_frame;
    release_all;
    wait_frames(4);
    settle;
    total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL multi_rel got held=%b want=0", bus.key_held); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL multi_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_bounce;
    sync_frame;
    for (int f = 0; f < 10; f++) begin
      pressed[1][3] = (f % 2 == 0);
      wait_frames(1);
    end
    pressed[1][3] = 1'b0;
    wait_frames(1);
    settle;
    total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL bounce_held got=%b want=0", bus.key_held); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL bounce_state got=%0d want=%0d", dut.state_q, IDLE); end
    total++; if (bus.key_code !== 4'b0000) begin bad++; $display("FAIL bounce_code got=%b want=0000", bus.key_code); end
  endtask

  task automatic test_invalid_col;
    exp_q.push_back({1'b0, 4'b0110});
    sync_frame;
    pressed[1][2] = 1'b1;
    wait_frames(1);
    force_val = 4'b0000;
    force_en  = 1'b1;
    wait_frames(1);
    force_val = 4'b0011;
    wait_frames(1);
    force_en  = 1'b0;
    wait_frames(2);
    settle;
    total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL abort_held got=%b want=0", bus.key_held); end
    total++; if (dut.state_q !== DEBOUNCE) begin bad++; $display("FAIL abort_state got=%0d want=%0d", dut.state_q, DEBOUNCE); end
    sync_frame;
    wait_frames(1);
    settle;
    total++; if (bus.key_held !== 1'b1) begin bad++; $display("FAIL abort_accept got held=%b want=1", bus.key_held); end
    total++; if (bus.key_code !== 4'b0110) begin bad++; $display("FAIL abort_code got=%b want=0110", bus.key_code); end
    exp_q.push_back({1'b1, 4'b0110});
    sync_frame;
    release_all;
    wait_frames(4);
    settle;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    sync_frame;
    pressed[2][1] = 1'b1;
    wait_frames(2);
    settle;
    total++; if (dut.state_q !== DEBOUNCE) begin bad++; $display("FAIL mid_pre got=%0d want=%0d", dut.state_q, DEBOUNCE); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.key_code !== 4'b0000) begin bad++; $display("FAIL mid_code got=%b want=0000", bus.key_code); end
    total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL mid_held got=%b want=0", bus.key_held); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL mid_state got=%0d want=%0d", dut.state_q, IDLE); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_frames(2);
    release_all;
    wait_frames(2);
    settle;
    total++; if (bus.key_held !== 1'b0) begin bad++; $display("FAIL mid_after got held=%b want=0", bus.key_held); end
    total++; if (bus.key_code !== 4'b0000) begin bad++; $display("FAIL mid_after_code got=%b want=0000", bus.key_code); end
  endtask

  initial begin
    release_all;
    test_reset;
    test_press;
    test_release;
    test_short;
    test_multi;
    test_bounce;
    test_invalid_col;
    test_reset_mid;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_pending got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_decoder.md
Name: keypad_decoder

Overview:
- Downstream consumer of the one-hot column scanner in the 4x4 keypad path.
- Watches the scanner's column output and the raw row pins, and synchronises the rows.
- Assembles one full-keypad frame per scan rotation and debounces across frames.
- Emits a registered key code with press/release pulses to the application logic.

Parameters:
- COLS, 4, number of scanned columns; must match the scanner's width.
- ROWS, 4, number of row inputs.
- DEBOUNCE_FRAMES, 4, consecutive identical frames needed to accept a press or a release (>=1).
- ROW_ACTIVE_LOW, 1, row pins read 0 when a key connects them.
- COL_ACTIVE_LOW, 0, polarity of the col input; must match the scanner setting.

Ports:
- clk  in  1  system clock; the same clock that drives the scanner.
- rst_n  in  1  asynchronous, active-low reset.
- col  in  COLS  column drive from the scanner; exactly one bit active.
- row_raw  in  ROWS  asynchronous row pins.
- key_code  out  CW+RW  {row_idx, col_idx}, where CW=$clog2(COLS) and RW=$clog2(ROWS); holds the last accepted key.
- key_valid  out  1  1-cycle pulse when a debounced press is accepted.
- key_held  out  1  level; high from acceptance until the release is accepted.
- key_release  out  1  1-cycle pulse when a debounced release is accepted.
- multi_key  out  1  level; the last completed frame saw more than one key.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0 and the state is IDLE.
  - Counters and frame accumulators are 0.
  - Row synchroniser flops are preset to the inactive level.
- Row path: 2-flop synchroniser, then normalised to active-high (row_s).
- Step detection:
  - col_d is col, registered.
  - step = (col != col_d).
  - On a step, row_s from the previous cycle is attributed to column col_d.
- Scan-rate constraint: the scanner dwell must be at least 4 clk cycles per column so that row_s reflects the current column.
- Invalid columns:
  - If col_d is not one-hot at a step, the frame is aborted: accumulators clear and no evaluation is made.
  - A normal frame then restarts at the next step out of column 0.
- Frame accumulation:
  - Each step adds popcount(row_s) to a hit count, saturating at 2.
  - The first hit's {row_idx, col_idx} is recorded; the lowest row index wins within a column.
- Frame end:
  - Occurs at the step leaving column COLS-1.
  - The frame is evaluated as NONE (0 hits), SINGLE(K) (1 hit) or MULTI (2 or more hits).
  - multi_key updates at every frame end.
  - Accumulators then clear.
- FSM (evaluated only at frame end):
  - IDLE: SINGLE(K) sets cand=K, cnt=1 and moves to DEBOUNCE. If DEBOUNCE_FRAMES==1, it goes straight to PRESSED instead.
  - DEBOUNCE:
    - SINGLE(cand) increments cnt.
    - When cnt reaches DEBOUNCE_FRAMES, move to PRESSED, load key_code=cand and pulse key_valid.
    - SINGLE(other), NONE or MULTI returns to IDLE.
  - PRESSED: key_held=1. NONE sets cnt=1 and moves to RELEASE; any other result stays in PRESSED.
  - RELEASE:
    - NONE increments cnt.
    - When cnt reaches DEBOUNCE_FRAMES, move to IDLE, clear key_held and pulse key_release.
    - Any key returns to PRESSED with cnt=0.
- Output timing:
  - key_valid and key_release are high for exactly the one cycle after the clk edge that sampled the closing step.
  - key_code is stable from that cycle until the next accepted press; release does not clear it.
- Blocking: a second key pressed while one is held forms MULTI or SINGLE frames. It never produces a new key_valid until a release is accepted.
- Reset mid-operation: an in-flight frame or debounce is discarded and no pulse is emitted.
- The cnt width is $clog2(DEBOUNCE_FRAMES+1); it never wraps.

Decomposition:
- Shared package keypad_pkg holds:
  - the state enum (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - the frame-result enum (NONE, SINGLE, MULTI);
  - the key_code width helper;
  - default COLS/ROWS constants shared with the scanner.
- One natural sub-module: row_sync, a parameterised 2-flop synchroniser with reset preset value.

Test Plan:
- Scanner instance with WAIT_TIME=3 (4-cycle dwell, 16-cycle frame). Hold row 2 low during col[1] for 5 frames -> exactly one key_valid with key_code=4'b1001, then key_held=1.
- Same key held for 3 frames only, then released -> no key_valid and the FSM is back in IDLE.
- Accepted key released for 4 frames -> key_release pulses once at the end of the 4th empty frame and key_held=0. key_code stays 4'b1001.
- Press (0,0) and (3,2) together -> multi_key=1 after the frame and no key_valid. Releasing (3,2) leaves a single key, which then debounces -> key_valid with key_code=4'b0000.
- Bounce: toggle row 1 every other frame for 10 frames -> no key_valid.
- Force col=4'b0000, then 4'b0011, for one dwell mid-frame -> frame aborted and no false key. Assert rst_n=0 mid-DEBOUNCE -> all outputs 0 immediately, with no pulse after release.
